// File: rtl/gf180mcu_fd_sc_mcu7t5v0__addf_serial_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding,
// legal WIDTH range and the bit-counter width helper.
package gf180mcu_fd_sc_mcu7t5v0__addf_serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } addf_state_e;

    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 64;

    // A 1-bit adder still needs a 1-bit counter register.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__addf_func.sv
// Functional model of the gf180mcu full-adder cell: S = A^B^CI, CO = majority.
module gf180mcu_fd_sc_mcu7t5v0__addf_func (
    input  logic A,
    input  logic B,
    input  logic CI,
    output logic S,
    output logic CO
);

    assign S  = A ^ B ^ CI;
    assign CO = (A & B) | (CI & (A ^ B));

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__addf_serial.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop,
// processing one bit pair per clock, LSB first, with valid/ready on both sides.
// Optional signed-overflow output: define GF180MCU_FD_SC_MCU7T5V0_ADDF_SERIAL_OVF_EN.
//
// state | meaning
// IDLE  | waiting for operands, IN_READY=1
// RUN   | one bit per cycle through the full adder
// DONE  | result held on S/CO(/OV), OUT_VALID=1
module gf180mcu_fd_sc_mcu7t5v0__addf_serial
    import gf180mcu_fd_sc_mcu7t5v0__addf_serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CI,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] S,
    output logic             CO
`ifdef GF180MCU_FD_SC_MCU7T5V0_ADDF_SERIAL_OVF_EN
    ,
    output logic             OV
`endif
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("addf_serial: WIDTH out of range");
    end

    addf_state_e      state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef GF180MCU_FD_SC_MCU7T5V0_ADDF_SERIAL_OVF_EN
    logic             ov_q, ov_d;
`endif

    logic fa_s;
    logic fa_co;

    gf180mcu_fd_sc_mcu7t5v0__addf_func u_fa (
        .A  (a_sh_q[0]),
        .B  (b_sh_q[0]),
        .CI (carry_q),
        .S  (fa_s),
        .CO (fa_co)
    );

    // Handshake flags come straight from the state register; reset masks IN_READY.
    assign IN_READY  = (state_q == ST_IDLE) && !RST;
    assign OUT_VALID = (state_q == ST_DONE);
    assign S         = sum_q;
    assign CO        = carry_q;
`ifdef GF180MCU_FD_SC_MCU7T5V0_ADDF_SERIAL_OVF_EN
    assign OV        = ov_q;
`endif

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
`ifdef GF180MCU_FD_SC_MCU7T5V0_ADDF_SERIAL_OVF_EN
            ov_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
`ifdef GF180MCU_FD_SC_MCU7T5V0_ADDF_SERIAL_OVF_EN
            ov_q    <= ov_d;
`endif
        end
    end

    // Next-state and datapath update; everything holds unless a state acts on it.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
`ifdef GF180MCU_FD_SC_MCU7T5V0_ADDF_SERIAL_OVF_EN
        ov_d    = ov_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (IN_VALID && IN_READY) begin
                    state_d = ST_RUN;
                    a_sh_d  = A;
                    b_sh_d  = B;
                    carry_d = CI;
                    sum_d   = '0;
                    cnt_d   = '0;
`ifdef GF180MCU_FD_SC_MCU7T5V0_ADDF_SERIAL_OVF_EN
                    ov_d    = 1'b0;
`endif
                end
            end
            ST_RUN: begin
                // Sum bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
                sum_d            = sum_q >> 1;
                sum_d[WIDTH-1]   = fa_s;
                a_sh_d           = a_sh_q >> 1;
                b_sh_d           = b_sh_q >> 1;
                carry_d          = fa_co;
                cnt_d            = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
`ifdef GF180MCU_FD_SC_MCU7T5V0_ADDF_SERIAL_OVF_EN
                    // Signed overflow: carry into the MSB differs from carry out of it.
                    ov_d    = carry_q ^ fa_co;
`endif
                end
            end
            ST_DONE: begin
                if (OUT_READY) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
